otter_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined OTTER core. Sits beside the decode stage and replaces the fixed two-deep hazard shift register with a scoreboard of configurable depth. Produces stall, bubble, flush and per-operand forwarding selects. Also keeps saturating stall/flush performance counters.

---
 rtl/otter_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_otter_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_hazard_ctrl.sv
// Hazard and forwarding controller for the pipelined OTTER core.
// A shift-register scoreboard of in-flight writers drives stall, bubble, flush and forwarding selects.
module otter_hazard_ctrl #(
  parameter int STAGES     = 3,
  parameter int FORWARD    = 1,
  parameter int LOAD_STAGE = 3,
  parameter int CNT_W      = 16
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           DEC_VALID,
  input  logic [4:0]                     DEC_RS1,
  input  logic [4:0]                     DEC_RS2,
  input  logic                           DEC_USES_RS1,
  input  logic                           DEC_USES_RS2,
  input  logic [4:0]                     DEC_RD,
  input  logic                           DEC_WRITES,
  input  logic                           DEC_IS_LOAD,
  input  logic                           REDIRECT,
  input  logic                           CNT_CLR,
  output logic                           STALL,
  output logic                           BUBBLE,
  output logic                           FLUSH,
  output logic [$clog2(STAGES+1)-1:0]    FWD_A,
  output logic [$clog2(STAGES+1)-1:0]    FWD_B,
  output logic [CNT_W-1:0]               STALL_CNT,
  output logic [CNT_W-1:0]               FLUSH_CNT
);

  localparam int FW = $clog2(STAGES+1);

  logic [STAGES:1] sb_valid;
  logic [STAGES:1] sb_load;
  logic [4:0]      sb_rd [1:STAGES];

  int   match_a, match_b;
  logic load_a, load_b;
  logic haz_a, haz_b;
  logic stall;
  logic enter;

  // Scan from oldest to youngest so the lowest matching index wins.
  always_comb begin
    match_a = 0;
    match_b = 0;
    load_a  = 1'b0;
    load_b  = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (DEC_USES_RS1 && (DEC_RS1 != 5'd0) && sb_valid[k] && (sb_rd[k] == DEC_RS1)) begin
        match_a = k;
        load_a  = sb_load[k];
      end
      if (DEC_USES_RS2 && (DEC_RS2 != 5'd0) && sb_valid[k] && (sb_rd[k] == DEC_RS2)) begin
        match_b = k;
        load_b  = sb_load[k];
      end
    end
  end

  // Without forwarding any in-flight writer blocks, including writeback.
  always_comb begin
    if (FORWARD == 0) begin
      haz_a = (match_a != 0);
      haz_b = (match_b != 0);
    end else begin
      haz_a = (match_a != 0) && load_a && (match_a < LOAD_STAGE);
      haz_b = (match_b != 0) && load_b && (match_b < LOAD_STAGE);
    end
  end

  assign stall  = ~RST & DEC_VALID & (haz_a | haz_b);
  assign STALL  = stall;
  assign BUBBLE = stall;
  assign FLUSH  = ~RST & REDIRECT & DEC_VALID & ~stall;
  assign enter  = DEC_VALID & DEC_WRITES & (DEC_RD != 5'd0) & ~stall;

  always_comb begin
    FWD_A = '0;
    FWD_B = '0;
    if (!RST && !stall && (FORWARD != 0)) begin
      FWD_A = FW'(match_a);
      FWD_B = FW'(match_b);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sb_valid <= '0;
      sb_load  <= '0;
    end else begin
      sb_valid <= {sb_valid[STAGES-1:1], enter};
      sb_load  <= {sb_load[STAGES-1:1], DEC_IS_LOAD};
    end
  end

  // Destination tags need no reset; they are qualified by sb_valid.
  always_ff @(posedge CLK) begin
    sb_rd[1] <= DEC_RD;
    for (int k = 2; k <= STAGES; k++) begin
      sb_rd[k] <= sb_rd[k-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || CNT_CLR) begin
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else begin
      if (stall && !(&STALL_CNT)) STALL_CNT <= STALL_CNT + 1'b1;
      if (FLUSH && !(&FLUSH_CNT)) FLUSH_CNT <= FLUSH_CNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed bench for otter_hazard_ctrl: default, stall-only and narrow-counter instances share stimulus.
module tb_otter_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       dec_valid;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       dec_uses_rs1, dec_uses_rs2, dec_writes, dec_is_load;
  logic       redirect, cnt_clr;

  logic        s0, bb0, fl0, s1, bb1, fl1, s2, bb2, fl2;
  logic [1:0]  fa0, fb0, fa1, fb1, fa2, fb2;
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;

  int vectors    = 0;
  int miscompares = 0;

  otter_hazard_ctrl #(.STAGES(3), .FORWARD(1), .LOAD_STAGE(3), .CNT_W(16)) dut_fwd (
    .CLK(clk), .RST(rst), .DEC_VALID(dec_valid), .DEC_RS1(dec_rs1), .DEC_RS2(dec_rs2),
    .DEC_USES_RS1(dec_uses_rs1), .DEC_USES_RS2(dec_uses_rs2), .DEC_RD(dec_rd),
    .DEC_WRITES(dec_writes), .DEC_IS_LOAD(dec_is_load), .REDIRECT(redirect), .CNT_CLR(cnt_clr),
    .STALL(s0), .BUBBLE(bb0), .FLUSH(fl0), .FWD_A(fa0), .FWD_B(fb0),
    .STALL_CNT(sc0), .FLUSH_CNT(fc0));

  otter_hazard_ctrl #(.STAGES(3), .FORWARD(0), .LOAD_STAGE(3), .CNT_W(16)) dut_nofwd (
    .CLK(clk), .RST(rst), .DEC_VALID(dec_valid), .DEC_RS1(dec_rs1), .DEC_RS2(dec_rs2),
    .DEC_USES_RS1(dec_uses_rs1), .DEC_USES_RS2(dec_uses_rs2), .DEC_RD(dec_rd),
    .DEC_WRITES(dec_writes), .DEC_IS_LOAD(dec_is_load), .REDIRECT(redirect), .CNT_CLR(cnt_clr),
    .STALL(s1), .BUBBLE(bb1), .FLUSH(fl1), .FWD_A(fa1), .FWD_B(fb1),
    .STALL_CNT(sc1), .FLUSH_CNT(fc1));

  otter_hazard_ctrl #(.STAGES(3), .FORWARD(1), .LOAD_STAGE(3), .CNT_W(4)) dut_narrow (
    .CLK(clk), .RST(rst), .DEC_VALID(dec_valid), .DEC_RS1(dec_rs1), .DEC_RS2(dec_rs2),
    .DEC_USES_RS1(dec_uses_rs1), .DEC_USES_RS2(dec_uses_rs2), .DEC_RD(dec_rd),
    .DEC_WRITES(dec_writes), .DEC_IS_LOAD(dec_is_load), .REDIRECT(redirect), .CNT_CLR(cnt_clr),
    .STALL(s2), .BUBBLE(bb2), .FLUSH(fl2), .FWD_A(fa2), .FWD_B(fb2),
    .STALL_CNT(sc2), .FLUSH_CNT(fc2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic wr, input logic ld);
    dec_valid    = v;
    dec_rs1      = rs1;
    dec_uses_rs1 = u1;
    dec_rs2      = rs2;
    dec_uses_rs2 = u2;
    dec_rd       = rd;
    dec_writes   = wr;
    dec_is_load  = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a live-looking decode and redirect: everything must be forced quiet.
    rst = 1'b1; redirect = 1'b1; cnt_clr = 1'b0;
    apply_stimulus(1, 5, 1, 5, 1, 5, 1, 0);
    #2;
    check_output("rst_stall", s0, 0);
    check_output("rst_flush", fl0, 0);
    check_output("rst_fwd_a", fa0, 0);
    tick(); tick();
    rst = 1'b0; redirect = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check_output("rst_stall_cnt", sc0, 0);
    check_output("rst_flush_cnt", fc0, 0);
    check_output("idle_stall", s0, 0);

    // ALU chain: forwarding index follows the writer down the pipe.
    apply_stimulus(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    apply_stimulus(1, 5, 1, 0, 0, 0, 0, 0);
    #2;
    check_output("alu_stall", s0, 0);
    check_output("alu_fwd_idx1", fa0, 1);
    tick(); #2;
    check_output("alu_fwd_idx2", fa0, 2);
    tick(); #2;
    check_output("alu_fwd_idx3", fa0, 3);
    tick(); #2;
    check_output("alu_fwd_retired", fa0, 0);

    // Load-use: two stall cycles, then forward from index 3.
    apply_stimulus(1, 0, 0, 0, 0, 6, 1, 1);
    tick();
    apply_stimulus(1, 6, 1, 6, 1, 7, 1, 0);
    #2;
    check_output("lu_stall_c1", s0, 1);
    check_output("lu_bubble_c1", bb0, 1);
    check_output("lu_fwd_a_stalled", fa0, 0);
    check_output("lu_fwd_b_stalled", fb0, 0);
    tick(); #2;
    check_output("lu_stall_c2", s0, 1);
    tick(); #2;
    check_output("lu_stall_done", s0, 0);
    check_output("lu_fwd_a", fa0, 3);
    check_output("lu_fwd_b", fb0, 3);
    check_output("lu_stall_cnt", sc0, 2);
    tick();

    // x0 never matches; youngest writer wins.
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0);
    tick();
    apply_stimulus(1, 0, 1, 0, 1, 8, 1, 0);
    #2;
    check_output("x0_stall", s0, 0);
    check_output("x0_fwd_a", fa0, 0);
    tick();
    apply_stimulus(1, 0, 0, 0, 0, 9, 1, 0);
    tick();
    apply_stimulus(1, 0, 0, 0, 0, 8, 1, 0);
    tick();
    apply_stimulus(1, 9, 1, 8, 1, 0, 0, 0);
    #2;
    check_output("young_fwd_a_x9", fa0, 2);
    check_output("young_fwd_b_x8", fb0, 1);
    tick();

    // Redirect without hazard, then a redirect held across a load-use stall.
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
    redirect = 1'b1;
    #2;
    check_output("redir_flush", fl0, 1);
    check_output("redir_stall", s0, 0);
    tick();
    redirect = 1'b0;
    #1;
    check_output("redir_flush_cnt1", fc0, 1);
    apply_stimulus(1, 0, 0, 0, 0, 10, 1, 1);
    tick();
    apply_stimulus(1, 10, 1, 0, 0, 0, 0, 0);
    redirect = 1'b1;
    #2;
    check_output("redir_lu_stall_c1", s0, 1);
    check_output("redir_lu_flush_c1", fl0, 0);
    tick(); #2;
    check_output("redir_lu_stall_c2", s0, 1);
    check_output("redir_lu_flush_c2", fl0, 0);
    tick(); #2;
    check_output("redir_lu_stall_done", s0, 0);
    check_output("redir_lu_flush_now", fl0, 1);
    check_output("redir_lu_fwd_a", fa0, 3);
    tick();
    redirect = 1'b0;
    #2;
    check_output("redir_flush_cnt2", fc0, 2);
    check_output("redir_stall_cnt4", sc0, 4);

    // Counter clear wins over a same-cycle stall increment.
    apply_stimulus(1, 0, 0, 0, 0, 11, 1, 1);
    tick();
    apply_stimulus(1, 11, 1, 0, 0, 0, 0, 0);
    cnt_clr = 1'b1;
    #2;
    check_output("clr_stall", s0, 1);
    tick();
    cnt_clr = 1'b0;
    #2;
    check_output("clr_stall_cnt", sc0, 0);
    check_output("clr_flush_cnt", fc0, 0);
    check_output("clr_still_stall", s0, 1);
    tick(); #2;
    check_output("clr_recount", sc0, 1);
    check_output("clr_stall_done", s0, 0);

    // Reset in the middle of a load-use stall.
    apply_stimulus(1, 0, 0, 0, 0, 12, 1, 1);
    tick();
    apply_stimulus(1, 12, 1, 0, 0, 0, 0, 0);
    redirect = 1'b1;
    #1;
    check_output("mid_stall_before_rst", s0, 1);
    rst = 1'b1;
    #1;
    check_output("mid_rst_stall", s0, 0);
    check_output("mid_rst_bubble", bb0, 0);
    check_output("mid_rst_flush", fl0, 0);
    check_output("mid_rst_fwd_a", fa0, 0);
    tick();
    rst = 1'b0;
    redirect = 1'b0;
    #2;
    check_output("post_rst_stall", s0, 0);
    check_output("post_rst_stall_cnt", sc0, 0);
    check_output("post_rst_flush_cnt", fc0, 0);
    check_output("post_rst_nofwd_cnt", sc1, 0);
    tick();

    // Stall-only mode: dependency at index 1 costs three cycles, no forwarding.
    apply_stimulus(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    apply_stimulus(1, 5, 1, 0, 0, 0, 0, 0);
    #2;
    check_output("nofwd_stall_c1", s1, 1);
    check_output("nofwd_fwd_c1", fa1, 0);
    check_output("fwd_inst_fwd_c1", fa0, 1);
    tick(); #2;
    check_output("nofwd_stall_c2", s1, 1);
    tick(); #2;
    check_output("nofwd_stall_c3_wb", s1, 1);
    check_output("nofwd_fwd_c3", fa1, 0);
    tick(); #2;
    check_output("nofwd_stall_done", s1, 0);
    check_output("nofwd_fwd_done", fa1, 0);
    check_output("nofwd_stall_cnt", sc1, 3);

    // Self-dependent load held in decode: 2 stalls per 3 cycles saturates a 4-bit counter.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    apply_stimulus(1, 1, 1, 0, 0, 1, 1, 1);
    for (int i = 0; i < 30; i++) tick();
    #2;
    check_output("sat_narrow_cnt", sc2, 15);
    check_output("sat_wide_cnt", sc0, 20);
    check_output("sat_phase_stall", s2, 0);
    check_output("sat_phase_fwd", fa2, 3);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #2;
    check_output("sat_clear", sc2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
